bp_decimator: RTL and testbench

BP_DECIMATOR -- requirements
Module: bp_decimator

---
 rtl/bp_decim_pkg.sv | 13 +
 rtl/bp_sync_fifo.sv | 64 ++++++
 rtl/bp_decimator.sv | 84 ++++++++
 tb/tb_bp_decimator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bp_decim_pkg.sv
// Shared defaults and derived widths for the band-pass decimator slice.
// The top and the FIFO take their parameter defaults from here.
package bp_decim_pkg;

    localparam int DEF_DATA_W     = 10;
    localparam int DEF_R_LOG2     = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    // The accumulator holds a full block sum of N max-value samples, so it never wraps.
    localparam int ACC_W  = DEF_DATA_W + DEF_R_LOG2;
    localparam int FILL_W = $clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/bp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Push and pop on the same edge both succeed, even when the FIFO is full.
module bp_sync_fifo
    import bp_decim_pkg::*;
#(
    parameter int W     = DEF_DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // When full, a push only lands if the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_decimator.sv
// Block-average decimator: sums N = 2**R_LOG2 accepted samples, pushes the
// truncated mean into an FWFT output FIFO and flags any dropped result.
module bp_decimator
    import bp_decim_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int R_LOG2     = DEF_R_LOG2,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    input  logic                          flush,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int AW = DATA_W + R_LOG2;

    // Handshake: din is taken on any edge with din_valid=1 (no backpressure);
    // dout leaves the FIFO on an edge where dout_valid=1 and dout_ready=1.
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [R_LOG2-1:0] cnt;
    logic              accept;
    logic              last;
    logic [DATA_W-1:0] result;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign accept = din_valid && !flush;
    assign last   = accept && (cnt == '1);
    assign sum    = acc + AW'(din);
    assign result = DATA_W'(sum >> R_LOG2);
    assign pop    = dout_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A full FIFO is never empty, so dout_ready alone decides whether the head leaves.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow <= 1'b0;
        end else if (last && fifo_full && !dout_ready) begin
            overflow <= 1'b1;
        end
    end

    bp_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (last),
        .pop   (pop),
        .din   (result),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill)
    );

    assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_bp_decimator.sv
// Directed bench for bp_decimator: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_bp_decimator;
    import bp_decim_pkg::*;

    localparam int W     = DEF_DATA_W;
    localparam int N     = 1 << DEF_R_LOG2;
    localparam int DEPTH = DEF_FIFO_DEPTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      din = '0;
    logic              din_valid = 1'b0;
    logic              flush = 1'b0;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic [FILL_W-1:0] fill;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           blk_q[$];
    bit           exp_ovf = 1'b0;

    bp_decimator dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fill       (fill),
        .overflow   (overflow)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // model: inputs only change on negedge, so they are stable here
    always @(posedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
            blk_q.delete();
            exp_ovf = 1'b0;
        end else begin
            bit popped;
            popped = (exp_q.size() > 0) && dout_ready;
            if (popped) void'(exp_q.pop_front());
            if (din_valid) begin
                blk_q.push_back(int'(din));
                if (blk_q.size() == N) begin
                    int s;
                    s = 0;
                    foreach (blk_q[i]) s += blk_q[i];
                    blk_q.delete();
                    if (exp_q.size() < DEPTH) exp_q.push_back(W'(s / N));
                    else exp_ovf = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            check("cyc_valid", int'(dout_valid), int'(exp_q.size() > 0));
            check("cyc_dout", int'(dout), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
            check("cyc_fill", int'(fill), exp_q.size());
            check("cyc_ovf", int'(overflow), int'(exp_ovf));
        end
    end

    // driver: apply inputs at negedge, return at the next negedge
    task automatic cyc(input bit v, input int d, input bit rdy, input bit fl = 1'b0, input bit r = 1'b0);
        din_valid  = v;
        din        = W'(d);
        dout_ready = rdy;
        flush      = fl;
        rst        = r;
        @(negedge clk);
    endtask

    task automatic feed(input int d, input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, d, rdy);
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        started = 1'b1;
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_ovf", int'(overflow), 0);

        // 5,10,12,15 -> 42>>2 = 10, visible for exactly one cycle
        cyc(1'b1, 5, 1'b1);
        cyc(1'b1, 10, 1'b1);
        cyc(1'b1, 12, 1'b1);
        check("blk1_not_yet", int'(dout_valid), 0);
        cyc(1'b1, 15, 1'b1);
        check("blk1_valid", int'(dout_valid), 1);
        check("blk1_dout", int'(dout), 10);
        cyc(1'b0, 0, 1'b1);
        check("blk1_one_cycle", int'(dout_valid), 0);

        // truncation and full-scale
        cyc(1'b1, 1, 1'b1); cyc(1'b1, 1, 1'b1); cyc(1'b1, 1, 1'b1); cyc(1'b1, 2, 1'b1);
        check("trunc_dout", int'(dout), 1);
        cyc(1'b0, 0, 1'b1);
        feed(1023, 4, 1'b1);
        check("max_dout", int'(dout), 1023);
        check("max_ovf", int'(overflow), 0);
        cyc(1'b0, 0, 1'b1);

        // backpressure: 5 results into a depth-4 FIFO
        feed(8, 16, 1'b0);
        check("bp_fill4", int'(fill), 4);
        check("bp_ovf_before", int'(overflow), 0);
        feed(8, 4, 1'b0);
        check("bp_ovf_after", int'(overflow), 1);
        check("bp_fill_held", int'(fill), 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_dout", int'(dout), 8);
            cyc(1'b0, 0, 1'b1);
        end
        check("bp_drained", int'(dout_valid), 0);
        check("bp_ovf_sticky", int'(overflow), 1);

        // flush mid-block; sample presented with flush is dropped
        feed(100, 2, 1'b1);
        cyc(1'b1, 500, 1'b1, 1'b1);
        check("fl_ovf_clr", int'(overflow), 0);
        check("fl_fill", int'(fill), 0);
        feed(16, 3, 1'b1);
        check("fl_not_yet", int'(dout_valid), 0);
        feed(16, 1, 1'b1);
        check("fl_dout", int'(dout), 16);
        cyc(1'b0, 0, 1'b1);
        check("fl_single", int'(dout_valid), 0);

        // reset with fill=3 and 3 samples pending
        feed(4, 15, 1'b0);
        check("rs_fill3", int'(fill), 3);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("rs_fill0", int'(fill), 0);
        check("rs_valid0", int'(dout_valid), 0);
        check("rs_dout0", int'(dout), 0);
        feed(7, 4, 1'b0);
        check("rs_new_blk", int'(dout), 7);
        check("rs_new_fill", int'(fill), 1);
        cyc(1'b0, 0, 1'b1);

        // push+pop while full keeps fill at 4 and preserves order
        for (int v = 1; v <= 4; v++) feed(v, 4, 1'b0);
        feed(5, 3, 1'b0);
        check("pp_full", int'(fill), 4);
        cyc(1'b1, 5, 1'b1);
        check("pp_fill", int'(fill), 4);
        check("pp_ovf", int'(overflow), 0);
        for (int v = 2; v <= 5; v++) begin
            check("pp_order", int'(dout), v);
            cyc(1'b0, 0, 1'b1);
        end
        check("pp_empty", int'(dout_valid), 0);

        cyc(1'b0, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
